crossbar_arbiter: RTL and testbench



---
 rtl/crossbar_arbiter.sv | 158 +++++++++++++++
 tb/tb_crossbar_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Round-robin arbiter sharing one crossbar config port among R requesters.
// Keeps the output-ownership table and issues one put per granted request.
module crossbar_arbiter #(
    parameter int W     = 3,
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int R     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [R-1:0]       req,
    input  logic [R*W-1:0]     req_from,
    input  logic [R*W-1:0]     req_to,
    output logic [R-1:0]       ack,
    output logic [R-1:0]       nak,
    output logic [W-1:0]       cb_from,
    output logic [W-1:0]       cb_to,
    output logic               cb_put,
    output logic [N_OUT-1:0]   owned,
    output logic               busy
);

    localparam int IW = $clog2(R);
    localparam logic signed [W:0] NIN_S  = (W+1)'(N_IN);
    localparam logic signed [W:0] NOUT_S = (W+1)'(N_OUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         id;
    logic [IW-1:0]         pick;
    logic                  found;
    logic signed [W-1:0]   lfrom;
    logic signed [W-1:0]   lto;
    logic signed [W:0]     fx;
    logic signed [W:0]     tx;
    logic                  fv;
    logic                  tv;
    logic [N_OUT-1:0]      tsel;
    logic [N_OUT-1:0]      own_vld;
    logic [IW-1:0]         own_id [N_OUT];
    logic                  hit_vld;
    logic                  hit_me;
    logic                  ok;
    logic                  put;
    logic                  set;
    logic                  clr;

    assign busy  = (state != IDLE);
    assign owned = own_vld;

    // Descending scan so the closest requester at or after ptr wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % R]) begin
                pick  = IW'((int'(ptr) + i) % R);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        fx      = {lfrom[W-1], lfrom};
        tx      = {lto[W-1], lto};
        fv      = !lfrom[W-1] && (fx < NIN_S);
        tv      = !lto[W-1] && (tx < NOUT_S);
        tsel    = '0;
        hit_me  = 1'b0;
        for (int o = 0; o < N_OUT; o++) begin
            tsel[o] = tv && (lto == W'(o));
            if (tsel[o] && own_vld[o] && own_id[o] == id)
                hit_me = 1'b1;
        end
        hit_vld = |(own_vld & tsel);
    end

    // A foreign owner blocks both subscribe and unsubscribe.
    always_comb begin
        ok  = 1'b0;
        put = 1'b0;
        set = 1'b0;
        clr = 1'b0;
        if (tv) begin
            if (fv) begin
                if (!hit_vld || hit_me) begin
                    ok  = 1'b1;
                    put = 1'b1;
                    set = 1'b1;
                end
            end else if (hit_me) begin
                ok  = 1'b1;
                put = 1'b1;
                clr = 1'b1;
            end else if (!hit_vld) begin
                ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            id      <= '0;
            lfrom   <= '0;
            lto     <= '0;
            ack     <= '0;
            nak     <= '0;
            cb_put  <= 1'b0;
            cb_from <= '0;
            cb_to   <= '0;
            own_vld <= '0;
            for (int o = 0; o < N_OUT; o++)
                own_id[o] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        id    <= pick;
                        lfrom <= req_from[int'(pick)*W +: W];
                        lto   <= req_to[int'(pick)*W +: W];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    for (int o = 0; o < N_OUT; o++) begin
                        if (tsel[o] && set) begin
                            own_vld[o] <= 1'b1;
                            own_id[o]  <= id;
                        end
                        if (tsel[o] && clr)
                            own_vld[o] <= 1'b0;
                    end
                    ack    <= ok ? (R'(1) << id) : '0;
                    nak    <= ok ? '0 : (R'(1) << id);
                    cb_put <= put;
                    if (put) begin
                        cb_from <= set ? lfrom : '1;
                        cb_to   <= lto;
                    end
                    ptr   <= (id == IW'(R - 1)) ? '0 : id + IW'(1);
                    state <= DONE;
                end
                DONE: begin
                    ack    <= '0;
                    nak    <= '0;
                    cb_put <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Scoreboard bench for crossbar_arbiter: directed cases then random batches
// checked against an ownership-table model.
module tb_crossbar_arbiter;

    localparam int W     = 3;
    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int R     = 4;

    logic               clock;
    logic               reset;
    logic [R-1:0]       req;
    logic [R*W-1:0]     req_from;
    logic [R*W-1:0]     req_to;
    logic [R-1:0]       ack;
    logic [R-1:0]       nak;
    logic [W-1:0]       cb_from;
    logic [W-1:0]       cb_to;
    logic               cb_put;
    logic [N_OUT-1:0]   owned;
    logic               busy;

    crossbar_arbiter #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT), .R(R)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_from (req_from),
        .req_to   (req_to),
        .ack      (ack),
        .nak      (nak),
        .cb_from  (cb_from),
        .cb_to    (cb_to),
        .cb_put   (cb_put),
        .owned    (owned),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int               id;
        bit               ok;
        bit               put;
        logic [W-1:0]     f;
        logic [W-1:0]     t;
        logic [N_OUT-1:0] own;
    } exp_t;

    exp_t                q[$];
    exp_t                e;
    int                  checks;
    int                  errors;
    int                  busy_run;
    int                  owner [N_OUT];
    int                  mptr;
    logic signed [W-1:0] cf [R];
    logic signed [W-1:0] ct [R];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N_OUT-1:0] model_owned();
        logic [N_OUT-1:0] m;
        m = '0;
        for (int o = 0; o < N_OUT; o++)
            m[o] = (owner[o] != -1);
        return m;
    endfunction

    task automatic model_clear();
        for (int o = 0; o < N_OUT; o++)
            owner[o] = -1;
        mptr = 0;
    endtask

    task automatic model_eval(input int id);
        int   fi;
        int   ti;
        exp_t x;
        fi    = $signed(cf[id]);
        ti    = $signed(ct[id]);
        x.id  = id;
        x.ok  = 0;
        x.put = 0;
        x.f   = '0;
        x.t   = ct[id];
        if (ti >= 0 && ti < N_OUT) begin
            if (fi >= 0 && fi < N_IN) begin
                if (owner[ti] == -1 || owner[ti] == id) begin
                    owner[ti] = id;
                    x.ok  = 1;
                    x.put = 1;
                    x.f   = cf[id];
                end
            end else if (owner[ti] == id) begin
                owner[ti] = -1;
                x.ok  = 1;
                x.put = 1;
                x.f   = '1;
            end else if (owner[ti] == -1) begin
                x.ok = 1;
            end
        end
        x.own = model_owned();
        q.push_back(x);
    endtask

    // All requesters in a batch stay high until served, so service
    // follows cyclic order starting at the pointer.
    task automatic run_batch(input logic [R-1:0] mask);
        logic [R-1:0] pending;
        logic [R-1:0] done;
        int           cyc;
        int           base;
        base = mptr;
        for (int i = 0; i < R; i++) begin
            if (mask[(base + i) % R]) begin
                model_eval((base + i) % R);
                mptr = ((base + i) % R + 1) % R;
            end
        end
        @(posedge clock);
        #1;
        for (int r = 0; r < R; r++) begin
            req_from[r*W +: W] = cf[r];
            req_to[r*W +: W]   = ct[r];
        end
        req     = mask;
        pending = mask;
        cyc     = 0;
        while (pending != 0 && cyc < 60) begin
            @(negedge clock);
            done = (ack | nak) & pending;
            @(posedge clock);
            #1;
            req     = req & ~done;
            pending = pending & ~done;
            cyc++;
        end
        if (pending != 0) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout pending %0h", pending);
            req = '0;
        end
    endtask

    task automatic hard_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        req   = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    always @(negedge clock) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
            end else begin
                if (busy_run != 0)
                    chk("busy_len", 32'(busy_run), 32'd2);
                busy_run = 0;
            end
            if ((ack | nak) != 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp ack %0h nak %0h", ack, nak);
                end else begin
                    e = q.pop_front();
                    chk("ack", 32'(ack), e.ok ? 32'(1 << e.id) : 32'd0);
                    chk("nak", 32'(nak), e.ok ? 32'd0 : 32'(1 << e.id));
                    chk("cb_put", 32'(cb_put), 32'(e.put));
                    if (e.put) begin
                        chk("cb_from", 32'(cb_from), 32'(e.f));
                        chk("cb_to", 32'(cb_to), 32'(e.t));
                    end
                    chk("owned", 32'(owned), 32'(e.own));
                end
            end else begin
                chk("idle_put", 32'(cb_put), 32'd0);
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        busy_run = 0;
        reset    = 1'b1;
        req      = '0;
        req_from = '0;
        req_to   = '0;
        model_clear();
        for (int r = 0; r < R; r++) begin
            cf[r] = '0;
            ct[r] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_nak", 32'(nak), 32'd0);
        chk("rst_put", 32'(cb_put), 32'd0);
        chk("rst_from", 32'(cb_from), 32'd0);
        chk("rst_to", 32'(cb_to), 32'd0);
        chk("rst_owned", 32'(owned), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        cf[0] = 3'sd0; ct[0] = 3'sd0;
        run_batch(4'b0001);
        cf[1] = 3'sd2; ct[1] = 3'sd0;
        run_batch(4'b0010);
        ct[1] = 3'sd3;
        run_batch(4'b0010);

        hard_reset();
        cf[0] = 3'sd0; ct[0] = 3'sd1;
        cf[1] = 3'sd1; ct[1] = 3'sd2;
        cf[2] = 3'sd2; ct[2] = 3'sd3;
        run_batch(4'b0111);
        cf[0] = 3'sd3; ct[0] = 3'sd0;
        cf[2] = 3'sd1; ct[2] = 3'sd3;
        run_batch(4'b0101);

        cf[0] = -3'sd1; ct[0] = 3'sd1;
        run_batch(4'b0001);
        run_batch(4'b0001);

        cf[3] = 3'sd1; ct[3] = 3'(5);
        run_batch(4'b1000);
        cf[3] = 3'(6); ct[3] = 3'sd1;
        run_batch(4'b1000);
        cf[0] = 3'(6); ct[0] = 3'sd2;
        run_batch(4'b0001);

        cf[0] = 3'sd0; ct[0] = 3'sd0;
        @(posedge clock);
        #1;
        req_from[0 +: W] = cf[0];
        req_to[0 +: W]   = ct[0];
        req = 4'b0001;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        req = '0;
        @(negedge clock);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_nak", 32'(nak), 32'd0);
        chk("abort_put", 32'(cb_put), 32'd0);
        chk("abort_owned", 32'(owned), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_clear();
        run_batch(4'b0001);

        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < R; r++) begin
                cf[r] = W'($urandom_range(0, (1 << W) - 1));
                ct[r] = W'($urandom_range(0, (1 << W) - 1));
            end
            run_batch(R'($urandom_range(1, (1 << R) - 1)));
        end

        for (int k = 0; k < 20 && q.size() != 0; k++)
            @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
